// File: rtl/stream_ctrl_regs.sv
// Register block and IDLE/RUN/ABORT sequencer for a stream engine, with a delayed cfg acknowledge.
// Optional timeout register/abort is built only when STREAM_CTRL_TIMEOUT_EN is defined.
module stream_ctrl_regs #(
  parameter int unsigned ACK_DLY = 1,
  parameter logic [31:0] ID_VAL  = 32'h5354_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  input  logic        sh_cl_flr_assert_q,
  input  logic        stream_beat,
  input  logic        stream_finished,
  output logic        stream_start,
  output logic        stream_abort,
  output logic        streaming_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [3:0] ACK_LOAD = 4'(ACK_DLY - 32'd1);

  state_t      state_r;
  logic [3:0]  ack_cnt_r;
  logic [31:0] cycles_r;
  logic [31:0] beats_r;
  logic [31:0] scratch_r;
  logic        done_r;

  logic [5:0]  word_s;
  logic        accept_s;
  logic        wr_s;
  logic        wr_ctrl_s;
  logic        wr_status_s;
  logic        start_req_s;
  logic        abort_req_s;
  logic        in_stream_s;
  logic        done_set_s;
  logic [31:0] rd_val_s;
  logic [31:0] timeout_rd_s;
  logic        timeout_flag_s;
  logic        timeout_hit_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^{cfg_addr[31:8], cfg_addr[1:0]};

  // Request decode and read mux; reads see register values from before this edge.
  always_comb begin
    word_s      = cfg_addr[7:2];
    accept_s    = (cfg_wr | cfg_rd) & (ack_cnt_r == 4'd0) & ~sh_cl_flr_assert_q;
    wr_s        = accept_s & cfg_wr;
    wr_ctrl_s   = wr_s & (word_s == 6'd0);
    wr_status_s = wr_s & (word_s == 6'd1);
    in_stream_s = (state_r != ST_IDLE);
    start_req_s = wr_ctrl_s & cfg_wdata[0] & (state_r == ST_IDLE);
    abort_req_s = wr_ctrl_s & cfg_wdata[1];
    done_set_s  = (state_r == ST_RUN) & stream_finished;
    case (word_s)
      6'd0:    rd_val_s = {31'd0, streaming_active};
      6'd1:    rd_val_s = {29'd0, timeout_flag_s, done_r, streaming_active};
      6'd2:    rd_val_s = cycles_r;
      6'd3:    rd_val_s = beats_r;
      6'd4:    rd_val_s = timeout_rd_s;
      6'd5:    rd_val_s = scratch_r;
      6'd6:    rd_val_s = ID_VAL;
      default: rd_val_s = 32'hDEAD_BEEF;
    endcase
  end

  // Ack pipeline: one pulse ACK_DLY cycles after an accepted request, read data captured at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt_r <= 4'd0;
      cfg_ack   <= 1'b0;
      cfg_rdata <= 32'd0;
    end else if (sh_cl_flr_assert_q) begin
      ack_cnt_r <= 4'd0;
      cfg_ack   <= 1'b0;
      cfg_rdata <= 32'd0;
    end else begin
      cfg_ack <= 1'b0;
      if (accept_s) begin
        cfg_rdata <= rd_val_s;
        if (ACK_LOAD == 4'd0) begin
          cfg_ack <= 1'b1;
        end else begin
          ack_cnt_r <= ACK_LOAD;
        end
      end else if (ack_cnt_r != 4'd0) begin
        ack_cnt_r <= ack_cnt_r - 4'd1;
        if (ack_cnt_r == 4'd1) begin
          cfg_ack <= 1'b1;
        end
      end
    end
  end

  // Stream sequencer; finish beats a same-cycle abort request or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      stream_start     <= 1'b0;
      stream_abort     <= 1'b0;
      streaming_active <= 1'b0;
    end else if (sh_cl_flr_assert_q) begin
      state_r          <= ST_IDLE;
      stream_start     <= 1'b0;
      stream_abort     <= 1'b0;
      streaming_active <= 1'b0;
    end else begin
      stream_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_req_s) begin
            state_r          <= ST_RUN;
            stream_start     <= 1'b1;
            streaming_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stream_finished) begin
            state_r          <= ST_IDLE;
            streaming_active <= 1'b0;
          end else if (abort_req_s | timeout_hit_s) begin
            state_r      <= ST_ABORT;
            stream_abort <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (stream_finished) begin
            state_r          <= ST_IDLE;
            stream_abort     <= 1'b0;
            streaming_active <= 1'b0;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          stream_abort     <= 1'b0;
          streaming_active <= 1'b0;
        end
      endcase
    end
  end

  // Counters, scratch and done flag; function-level reset keeps SCRATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_r  <= 32'd0;
      beats_r   <= 32'd0;
      scratch_r <= 32'd0;
      done_r    <= 1'b0;
    end else if (sh_cl_flr_assert_q) begin
      cycles_r <= 32'd0;
      beats_r  <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      if (start_req_s) begin
        cycles_r <= 32'd0;
        beats_r  <= 32'd0;
      end else if (in_stream_s) begin
        if (cycles_r != 32'hFFFF_FFFF) begin
          cycles_r <= cycles_r + 32'd1;
        end
        if (stream_beat) begin
          beats_r <= beats_r + 32'd1;
        end
      end
      if (wr_s && (word_s == 6'd5)) begin
        scratch_r <= cfg_wdata;
      end
      if (start_req_s) begin
        done_r <= 1'b0;
      end else if (done_set_s) begin
        done_r <= 1'b1;
      end else if (wr_status_s && cfg_wdata[1]) begin
        done_r <= 1'b0;
      end
    end
  end

`ifdef STREAM_CTRL_TIMEOUT_EN
  logic [31:0] timeout_r;
  logic        timeout_flag_r;

  // Timeout limit and sticky timeout flag (set wins over W1C).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r      <= 32'd0;
      timeout_flag_r <= 1'b0;
    end else if (sh_cl_flr_assert_q) begin
      timeout_r      <= 32'd0;
      timeout_flag_r <= 1'b0;
    end else begin
      if (wr_s && (word_s == 6'd4)) begin
        timeout_r <= cfg_wdata;
      end
      if (start_req_s) begin
        timeout_flag_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_flag_r <= 1'b1;
      end else if (wr_status_s && cfg_wdata[2]) begin
        timeout_flag_r <= 1'b0;
      end
    end
  end

  assign timeout_hit_s  = (state_r == ST_RUN) & ~stream_finished & (timeout_r != 32'd0)
                        & (cycles_r == (timeout_r - 32'd1));
  assign timeout_flag_s = timeout_flag_r;
  assign timeout_rd_s   = timeout_r;
`else
  assign timeout_hit_s  = 1'b0;
  assign timeout_flag_s = 1'b0;
  assign timeout_rd_s   = 32'hDEAD_BEEF;
`endif

endmodule

// File: tb/tb_stream_ctrl_regs.sv
// Self-checking bench for stream_ctrl_regs: a register-level model drives per-cycle checks
// of two instances (ACK_DLY 1 and 3) plus hand-computed literal expectations.
module tb_stream_ctrl_regs;

`ifdef STREAM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_addr = 32'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic        flr = 1'b0;
  logic        beat = 1'b0;
  logic        fin = 1'b0;

  logic        a_ack, a_start, a_abort, a_active;
  logic [31:0] a_rdata;
  logic        b_ack, b_start, b_abort, b_active;
  logic [31:0] b_rdata;

  stream_ctrl_regs #(.ACK_DLY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_ack(a_ack), .cfg_rdata(a_rdata),
    .sh_cl_flr_assert_q(flr), .stream_beat(beat), .stream_finished(fin),
    .stream_start(a_start), .stream_abort(a_abort), .streaming_active(a_active)
  );

  stream_ctrl_regs #(.ACK_DLY(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_ack(b_ack), .cfg_rdata(b_rdata),
    .sh_cl_flr_assert_q(flr), .stream_beat(beat), .stream_finished(fin),
    .stream_start(b_start), .stream_abort(b_abort), .streaming_active(b_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: what the register map and stream status must hold.
  bit          m_run, m_abt, m_start, m_done, m_tof;
  logic [31:0] m_cycles, m_beats, m_timeout, m_scratch;
  int          m_cyc = 0;
  int          pend_due [2];
  logic [31:0] pend_data [2];
  bit          e_ack [2];
  logic [31:0] e_rdata [2];

  // Bench-side observation counters.
  int t_cyc = 0, start_at = 0, n_start = 0, n_abort_rise = 0, n_aack = 0, n_back = 0;
  bit prev_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] w);
    case (w)
      6'd0:    return {31'd0, (m_run | m_abt)};
      6'd1:    return {29'd0, m_tof, m_done, (m_run | m_abt)};
      6'd2:    return m_cycles;
      6'd3:    return m_beats;
      6'd4:    return TO_EN ? m_timeout : 32'hDEAD_BEEF;
      6'd5:    return m_scratch;
      6'd6:    return 32'h5354_0001;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_abt = 1'b0; m_start = 1'b0; m_done = 1'b0; m_tof = 1'b0;
    m_cycles = 32'd0; m_beats = 32'd0; m_timeout = 32'd0; m_scratch = 32'd0;
    for (int i = 0; i < 2; i++) begin
      pend_due[i] = -1; pend_data[i] = 32'd0; e_ack[i] = 1'b0; e_rdata[i] = 32'd0;
    end
  endtask

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic model_edge(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic fl, input logic bt,
                            input logic fn, input logic rstv);
    logic [5:0]  w;
    logic [31:0] rv;
    bit act, w0, hit;
    if (rstv) begin
      model_reset();
    end else if (fl) begin
      m_run = 1'b0; m_abt = 1'b0; m_start = 1'b0; m_done = 1'b0; m_tof = 1'b0;
      m_cycles = 32'd0; m_beats = 32'd0; m_timeout = 32'd0;
      for (int i = 0; i < 2; i++) pend_due[i] = -1;
    end else begin
      w = addr[7:2];
      rv = m_read(w);
      act = m_run | m_abt;
      w0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if ((wr | rd) && !(pend_due[i] > m_cyc)) begin
          pend_due[i]  = m_cyc + ((i == 0) ? 1 : 3);
          pend_data[i] = rv;
          if (i == 0) w0 = wr;
        end
      end
      hit = TO_EN && m_run && (m_timeout != 32'd0) && (m_cycles == m_timeout - 32'd1);
      if (act) begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        if (bt) m_beats = m_beats + 32'd1;
      end
      if (w0 && w == 6'd1) begin
        if (wdata[1]) m_done = 1'b0;
        if (wdata[2]) m_tof = 1'b0;
      end
      if (w0 && w == 6'd4 && TO_EN) m_timeout = wdata;
      if (w0 && w == 6'd5) m_scratch = wdata;
      m_start = 1'b0;
      if (!act) begin
        if (w0 && w == 6'd0 && wdata[0]) begin
          m_run = 1'b1; m_start = 1'b1;
          m_cycles = 32'd0; m_beats = 32'd0; m_done = 1'b0; m_tof = 1'b0;
        end
      end else if (m_run) begin
        if (fn) begin
          m_run = 1'b0; m_done = 1'b1;
        end else if ((w0 && w == 6'd0 && wdata[1]) || hit) begin
          m_run = 1'b0; m_abt = 1'b1;
          if (hit) m_tof = 1'b1;
        end
      end else if (fn) begin
        m_abt = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      e_ack[i]   = (pend_due[i] == m_cyc + 1);
      e_rdata[i] = pend_data[i];
    end
    m_cyc++;
  endtask

  // One clock: snapshot inputs, wait past the edge, advance model and observers.
  task automatic step();
    logic s_wr, s_rd, s_fl, s_bt, s_fn, s_rst;
    logic [31:0] s_addr, s_wdata;
    s_wr = cfg_wr; s_rd = cfg_rd; s_fl = flr; s_bt = beat; s_fn = fin; s_rst = rst;
    s_addr = cfg_addr; s_wdata = cfg_wdata;
    @(posedge clk);
    #1;
    model_edge(s_wr, s_rd, s_addr, s_wdata, s_fl, s_bt, s_fn, s_rst);
    t_cyc++;
    if (a_start) begin start_at = t_cyc; n_start++; end
    if (a_abort && !prev_abort) n_abort_rise++;
    prev_abort = a_abort;
    if (a_ack) n_aack++;
    if (b_ack) n_back++;
  endtask

  // Issue one request and wait for both instances to acknowledge it.
  task automatic req(input logic is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic with_fin, output logic [31:0] rdata);
    int lat1, lat3;
    lat1 = 0; lat3 = 0; rdata = 32'd0;
    cfg_addr = addr; cfg_wdata = wdata; cfg_wr = is_wr; cfg_rd = ~is_wr; fin = with_fin;
    step();
    cfg_wr = 1'b0; cfg_rd = 1'b0; fin = 1'b0;
    for (int n = 1; n <= 8 && lat3 == 0; n++) begin
      if (n > 1) step();
      if (a_ack && lat1 == 0) begin lat1 = n; rdata = a_rdata; end
      if (b_ack && lat3 == 0) lat3 = n;
    end
    check("ack_latency_dly1", lat1, 32'd1);
    check("ack_latency_dly3", lat3, 32'd3);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    req(1'b1, addr, data, 1'b0, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    req(1'b0, addr, 32'd0, 1'b0, d);
    check(name, d, exp);
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check1("cyc_ack_dly1", a_ack, e_ack[0]);
        check1("cyc_ack_dly3", b_ack, e_ack[1]);
        if (e_ack[0]) check("cyc_rdata_dly1", a_rdata, e_rdata[0]);
        if (e_ack[1]) check("cyc_rdata_dly3", b_rdata, e_rdata[1]);
        check1("cyc_start", a_start, m_start);
        check1("cyc_abort", a_abort, m_abt);
        check1("cyc_active", a_active, m_run | m_abt);
        check1("cyc_start_dly3", b_start, m_start);
        check1("cyc_abort_dly3", b_abort, m_abt);
        check1("cyc_active_dly3", b_active, m_run | m_abt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, na, ab, ns;
    logic [31:0] d;
    model_reset();
    step();
    step();
    check1("reset_ack", a_ack, 1'b0);
    check("reset_rdata", a_rdata, 32'd0);
    check1("reset_start", a_start, 1'b0);
    check1("reset_abort", a_abort, 1'b0);
    check1("reset_active", a_active, 1'b0);
    chk_en = 1'b1;

    // Release reset and request on the very first edge.
    rst = 1'b0;
    rd_chk("id_read", 32'h18, 32'h5354_0001);
    rd_chk("unmapped_0x40", 32'h40, 32'hDEAD_BEEF);
    rd_chk("unmapped_0x1c", 32'h1C, 32'hDEAD_BEEF);
    wr(32'h14, 32'hA5A5_0F0F);
    rd_chk("scratch_rw", 32'h14, 32'hA5A5_0F0F);
    wr(32'h08, 32'h1234_5678);
    rd_chk("cycles_read_only", 32'h08, 32'd0);

    // Start, ten beats, finish.
    ns = n_start;
    wr(32'h00, 32'd1);
    check("start_pulses", n_start - ns, 32'd1);
    check1("active_in_run", a_active, 1'b1);
    rd_chk("ctrl_read_run", 32'h00, 32'd1);
    beat = 1'b1;
    repeat (10) step();
    beat = 1'b0;
    fin = 1'b1;
    step();
    fin = 1'b0;
    check1("active_after_finish", a_active, 1'b0);
    rd_chk("beats_10", 32'h0C, 32'd10);
    rd_chk("status_done", 32'h04, 32'h2);
    wr(32'h04, 32'h2);
    rd_chk("status_w1c", 32'h04, 32'h0);

    // Manual abort; start while aborting is ignored.
    wr(32'h00, 32'd1);
    wr(32'h00, 32'd2);
    check1("abort_level", a_abort, 1'b1);
    ns = n_start;
    wr(32'h00, 32'd1);
    check("start_ignored_in_abort", n_start - ns, 32'd0);
    repeat (3) step();
    check1("abort_held", a_abort, 1'b1);
    fin = 1'b1;
    step();
    fin = 1'b0;
    check1("abort_released", a_abort, 1'b0);
    rd_chk("status_after_abort", 32'h04, 32'h0);

    // Abort request coincident with finish: finish wins.
    ab = n_abort_rise;
    wr(32'h00, 32'd1);
    repeat (4) step();
    req(1'b1, 32'h00, 32'd2, 1'b1, d);
    check("no_abort_on_race", n_abort_rise - ab, 32'd0);
    rd_chk("status_race_done", 32'h04, 32'h2);
    wr(32'h04, 32'h2);

`ifdef STREAM_CTRL_TIMEOUT_EN
    wr(32'h10, 32'd100);
    rd_chk("timeout_rw", 32'h10, 32'd100);
    wr(32'h00, 32'd1);
    for (int n = 0; n < 150 && !a_abort; n++) step();
    check("timeout_abort_delay", t_cyc - start_at, 32'd100);
    rd_chk("status_timeout_abort", 32'h04, 32'h5);
    fin = 1'b1;
    step();
    fin = 1'b0;
    rd_chk("status_timeout_idle", 32'h04, 32'h4);
    wr(32'h04, 32'h4);
    rd_chk("status_timeout_w1c", 32'h04, 32'h0);
    wr(32'h10, 32'd0);
`else
    wr(32'h10, 32'd100);
    rd_chk("timeout_absent", 32'h10, 32'hDEAD_BEEF);
    wr(32'h00, 32'd1);
    repeat (120) step();
    check1("no_timeout_abort", a_abort, 1'b0);
    fin = 1'b1;
    step();
    fin = 1'b0;
    rd_chk("status_no_timeout", 32'h04, 32'h2);
    wr(32'h04, 32'h2);
`endif

    // Request during a pending ack is dropped by the slow instance only.
    na = n_aack; nb = n_back;
    cfg_rd = 1'b1; cfg_addr = 32'h18;
    step();
    cfg_addr = 32'h40;
    step();
    cfg_rd = 1'b0;
    repeat (5) step();
    check("drop_acks_dly1", n_aack - na, 32'd2);
    check("drop_acks_dly3", n_back - nb, 32'd1);

    // Function-level reset mid-run keeps SCRATCH and clears the rest.
    wr(32'h14, 32'hA5A5_0F0F);
    wr(32'h00, 32'd1);
    repeat (5) step();
    flr = 1'b1;
    step();
    flr = 1'b0;
    check1("flr_idle", a_active, 1'b0);
    rd_chk("flr_cycles", 32'h08, 32'd0);
    rd_chk("flr_scratch", 32'h14, 32'hA5A5_0F0F);

    // Function-level reset cancels a pending ack.
    nb = n_back;
    cfg_rd = 1'b1; cfg_addr = 32'h18;
    step();
    cfg_rd = 1'b0;
    flr = 1'b1;
    step();
    flr = 1'b0;
    repeat (5) step();
    check("flr_cancels_ack", n_back - nb, 32'd0);

    // Asynchronous reset mid-run with an ack pending.
    wr(32'h00, 32'd1);
    cfg_rd = 1'b1; cfg_addr = 32'h08;
    step();
    cfg_rd = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check1("rst_async_ack", a_ack, 1'b0);
    check("rst_async_rdata", a_rdata, 32'd0);
    check1("rst_async_active", a_active, 1'b0);
    check1("rst_async_abort", a_abort, 1'b0);
    check1("rst_async_ack_dly3", b_ack, 1'b0);
    nb = n_back;
    step();
    step();
    rst = 1'b0;
    rd_chk("id_after_rst", 32'h18, 32'h5354_0001);
    check("no_stale_ack_after_rst", n_back - nb, 32'd1);
    rd_chk("scratch_cleared_by_rst", 32'h14, 32'd0);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_ctrl_regs.md
STREAM_CTRL_REGS -- requirements
Module: stream_ctrl_regs

Interface
REQ-001 SHALL have parameter ACK_DLY, default 1, cycles from cfg_wr/cfg_rd to cfg_ack (legal 1..15).
REQ-002 SHALL have parameter ID_VAL, default 32'h5354_0001, value returned by the ID register.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 cfg_addr  in  32  register address; bits [7:2] select the word.
REQ-006 cfg_wdata  in  32  write data, valid with cfg_wr.
REQ-007 cfg_wr / cfg_rd  in  1 each  single-cycle request pulses from the cfg initiator.
REQ-008 cfg_ack  out  1  single-cycle completion pulse.
REQ-009 cfg_rdata  out  32  read data, valid while cfg_ack=1.
REQ-010 sh_cl_flr_assert_q  in  1  function-level reset request.
REQ-011 stream_beat  in  1  one pulse per streamed beat.
REQ-012 stream_finished  in  1  pulse from the engine: stream complete or stopped.
REQ-013 stream_start  out  1  single-cycle start pulse to the engine.
REQ-014 stream_abort  out  1  level; held until stream_finished.
REQ-015 streaming_active  out  1  high in RUN or ABORT.

Function
REQ-016 Register map, word offset: 0x00 CTRL, 0x04 STATUS, 0x08 CYCLES, 0x0C BEATS, 0x10 TIMEOUT, 0x14 SCRATCH, 0x18 ID; other offsets read 32'hDEAD_BEEF, writes ignored, still acked.
REQ-017 Each cfg_wr/cfg_rd SHALL yield exactly one cfg_ack pulse ACK_DLY cycles later; a request arriving while an ack is pending SHALL be dropped without ack.
REQ-018 Read data SHALL be sampled when the request arrives and held until cfg_ack.
REQ-019 FSM states IDLE, RUN, ABORT; reset state IDLE.
REQ-020 IDLE->RUN on CTRL write with wdata[0]=1: pulse stream_start the next cycle, clear CYCLES, BEATS, STATUS.done, STATUS.timeout.
REQ-021 Start write in RUN or ABORT SHALL be ignored (still acked).
REQ-022 RUN->IDLE on stream_finished; set STATUS.done.
REQ-023 RUN->ABORT on CTRL write with wdata[1]=1, or on timeout (REQ-027); assert stream_abort.
REQ-024 ABORT->IDLE on stream_finished; deassert stream_abort; STATUS.done stays 0.
REQ-025 stream_finished coincident with an abort request in RUN: finished wins, go IDLE, done=1, no abort.
REQ-026 CYCLES increments each cycle in RUN/ABORT, saturates at 32'hFFFF_FFFF; BEATS increments per stream_beat in RUN/ABORT, wraps at 2^32.
REQ-027 Timeout: TIMEOUT!=0 and CYCLES==TIMEOUT-1 in RUN -> ABORT next cycle, STATUS.timeout=1.
REQ-028 STATUS read: bit0 active, bit1 done, bit2 timeout; write 1 to bit1/bit2 clears it (W1C); set and clear in the same cycle -> set wins.
REQ-029 CTRL read: bit0 streaming_active, other bits 0.
REQ-030 SCRATCH and TIMEOUT SHALL be full 32-bit R/W; CYCLES, BEATS, ID read-only.
REQ-031 sh_cl_flr_assert_q SHALL force IDLE, deassert stream_abort, clear all registers except SCRATCH, and cancel any pending ack.

Reset
REQ-032 rst SHALL clear all state immediately: FSM IDLE, cfg_ack=0, cfg_rdata=0, stream_start=0, stream_abort=0, streaming_active=0, all registers 0.
REQ-033 On rst deassertion the block SHALL accept a request on the first clock edge.

Configuration
REQ-034 With STREAM_CTRL_TIMEOUT_EN defined, TIMEOUT register and REQ-027 SHALL be implemented.
REQ-035 Without STREAM_CTRL_TIMEOUT_EN, offset 0x10 reads 32'hDEAD_BEEF, writes are ignored, and STATUS.timeout reads 0.

Verification
REQ-036 Read 0x18, ACK_DLY=1 -> cfg_ack exactly 1 cycle later, rdata=32'h5354_0001; read 0x40 -> 32'hDEAD_BEEF.
REQ-037 Write CTRL=1, 10 stream_beat pulses, then stream_finished -> stream_start 1 cycle, BEATS=10, STATUS=32'h2, streaming_active=0.
REQ-038 TIMEOUT=100, start, no finish -> stream_abort rises 100 cycles after start, STATUS.timeout=1; finished -> IDLE, done=0.
REQ-039 In RUN, CTRL=2 in same cycle as stream_finished -> IDLE, done=1, stream_abort never asserted.
REQ-040 SCRATCH=32'hA5A5_0F0F, RUN, assert flr -> IDLE, CYCLES=0, SCRATCH readback 32'hA5A5_0F0F.
REQ-041 rst asserted mid-RUN with ack pending -> all outputs 0 same cycle, no cfg_ack after release.
